// File: rtl/rs232out_fifo.sv
// rs232out_fifo: transmit buffer in front of the rs232out serialiser.
// Producer pushes bytes over in_valid/in_ready; one byte is handed to
// rs232out (tx_data/tx_we) whenever the FIFO is non-empty and tx_busy is low.
// Latency: byte pushed in cycle N into an empty FIFO strobes tx_we in cycle N+1.
// Backpressure: in_ready drops when all 2^DEPTH_LOG2 entries are occupied.
//
// Ports:
//   clk25MHz  in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   in_data   in   [7:0] byte offered by producer
//   in_valid  in   producer offers in_data
//   in_ready  out  FIFO accepts this cycle (push = in_valid & in_ready)
//   tx_data   out  [7:0] byte to rs232out.data (don't-care when tx_we=0)
//   tx_we     out  write strobe to rs232out.we
//   tx_busy   in   rs232out.busy
//   level     out  [DEPTH_LOG2:0] number of stored bytes
//
// Optional feature: define RS232OUT_FIFO_CRLF_EN to emit 8'h0D ahead of every
// stored 8'h0A. The inserted CR never occupies a FIFO entry.

module rs232out_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk25MHz,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_we,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = DEPTH[DEPTH_LOG2:0];

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic [7:0] head;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);
  assign head  = mem[rd_ptr_q];

  // A pop in the same cycle does not free a slot for the push: no bypass.
  assign in_ready = ~full & ~rst;
  assign push     = in_valid & in_ready;

  // rs232out raises busy the cycle after it samples we, so a strobe here
  // transfers exactly one byte.
  assign tx_we = ~empty & ~tx_busy & ~rst;

`ifdef RS232OUT_FIFO_CRLF_EN
  logic cr_sent_q, cr_sent_d;
  logic insert_cr;

  // A head LF is sent in two strobes: first a synthetic CR (head kept),
  // then the LF itself (head popped).
  assign insert_cr = (head == 8'h0A) & ~cr_sent_q;
  assign tx_data   = insert_cr ? 8'h0D : head;
  assign pop       = tx_we & ~insert_cr;

  always_comb begin
    cr_sent_d = cr_sent_q;
    if (tx_we) begin
      cr_sent_d = insert_cr;
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      cr_sent_q <= 1'b0;
    end else begin
      cr_sent_q <= cr_sent_d;
    end
  end
`else
  assign tx_data = head;
  assign pop     = tx_we;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Push and pop together leave the count unchanged.
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset; queued bytes are dropped by pointer reset.
  always_ff @(posedge clk25MHz) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  assign level = level_q;

endmodule

// File: tb/tb_rs232out_fifo.sv
// tb_rs232out_fifo: directed and randomized checking of rs232out_fifo against
// a queue-based model of the transmit buffer.
// Outputs are compared each cycle shortly after the falling edge.

module tb_rs232out_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk25MHz = 1'b0;
  logic                rst      = 1'b1;
  logic [7:0]          in_data  = 8'h00;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [7:0]          tx_data;
  logic                tx_we;
  logic                tx_busy  = 1'b1;
  logic [DEPTH_LOG2:0] level;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: stored bytes in order, plus the "CR already sent" flag.
  logic [7:0] q[$];
  bit         m_cr = 1'b0;

  rs232out_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk25MHz (clk25MHz),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_we    (tx_we),
    .tx_busy  (tx_busy),
    .level    (level)
  );

  always #20 clk25MHz = ~clk25MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic b, input logic r);
    bit         e_rdy, e_we, is_cr;
    logic [7:0] e_dat;
    @(negedge clk25MHz);
    in_valid = v;
    in_data  = d;
    tx_busy  = b;
    rst      = r;
    #1;
    e_rdy = !r && (q.size() < DEPTH);
    e_we  = !r && (q.size() > 0) && !b;
    is_cr = 1'b0;
    e_dat = 8'h00;
    if (q.size() > 0) begin
      e_dat = q[0];
`ifdef RS232OUT_FIFO_CRLF_EN
      if (q[0] == 8'h0A && !m_cr) begin
        is_cr = 1'b1;
        e_dat = 8'h0D;
      end
`endif
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
    chk("tx_we", {31'd0, tx_we}, {31'd0, e_we});
    chk("level", {27'd0, level}, q.size());
    if (e_we) chk("tx_data", {24'd0, tx_data}, {24'd0, e_dat});
    @(posedge clk25MHz);
    if (r) begin
      q.delete();
      m_cr = 1'b0;
    end else begin
      if (e_we) begin
        if (is_cr) begin
          m_cr = 1'b1;
        end else begin
          void'(q.pop_front());
          m_cr = 1'b0;
        end
      end
      if (v && e_rdy) q.push_back(d);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() > 0; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // Bring state out of X before checking anything.
    repeat (2) @(posedge clk25MHz);

    // Reset held 3 cycles with a producer offering data.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single byte: strobe the cycle after the push.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full while busy; 17th byte must be refused.
    for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    // Push attempt while full coinciding with a pop: still refused.
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    // Drain with busy released in single-cycle gaps.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    drain();

    // Simultaneous push and pop at level 5, running pointers through the wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    drain();

    // Reset in the middle of a drain.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // LF followed by ordinary byte, busy toggling.
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    step(1'b1, 8'h42, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'(i % 2), 1'b0);
    drain();

    // Randomized traffic: LF-heavy data, random busy, occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic       v, b, r;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom);
      b = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(v, d, b, r);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
